// File: rtl/audio_pdm_out.sv
// Generic single-clock FIFO, power-of-two depth.
// Latency: pushed word visible at rd_dat the cycle after the push.
// Backpressure: wr_rdy drops when full; a pop while full does not free the push slot that cycle.
module fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         wr_vld,
    output logic         wr_rdy,
    input  logic [W-1:0] wr_dat,
    output logic         rd_vld,
    input  logic         rd_rdy,
    output logic [W-1:0] rd_dat
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   count;
    logic          push, pop;

    assign wr_rdy = (count != FULL);
    assign rd_vld = (count != '0);
    assign push   = wr_vld && wr_rdy;
    assign pop    = rd_rdy && rd_vld;
    assign rd_dat = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= wr_dat;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end
endmodule

// Multi-channel 1-bit audio output: frame FIFO, one frame per sample period, PWM or sigma-delta.
// Latency: audio_out is registered, 1 cycle behind phase/accumulator; new frame applies from the tick.
// Backpressure: s_ready = FIFO not full; pushes are accepted even while ena=0.
module audio_pdm_out #(
    parameter int CHANNELS   = 2,
    parameter int WIDTH      = 8,
    parameter int SAMPLE_DIV = 256,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      ena,
    input  logic                      mode,
    input  logic                      s_valid,
    output logic                      s_ready,
    input  logic [CHANNELS*WIDTH-1:0] s_data,
    output logic [CHANNELS-1:0]       audio_out,
    output logic                      sample_tick,
    output logic                      underrun,
    input  logic                      clr_underrun
);
    localparam int FW = CHANNELS * WIDTH;
    localparam int CW = $clog2(SAMPLE_DIV);
    localparam logic [CW-1:0] CNT_MAX = CW'(SAMPLE_DIV - 1);

    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] phase;
    logic             boundary;
    logic             mode_act;
    logic [FW-1:0]    cur_sample;
    logic [FW-1:0]    acc;
    logic [WIDTH:0]   sd_sum [CHANNELS];
    logic             fifo_vld;
    logic [FW-1:0]    fifo_dat;

    assign boundary = ena && (cnt == CNT_MAX);
    assign phase    = cnt[WIDTH-1:0];

    // Pop is only requested at a boundary; an empty FIFO there is an underrun.
    fifo #(.W(FW), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk    (clk),
        .rst_n  (rst_n),
        .wr_vld (s_valid),
        .wr_rdy (s_ready),
        .wr_dat (s_data),
        .rd_vld (fifo_vld),
        .rd_rdy (boundary),
        .rd_dat (fifo_dat)
    );

    // The carry of the sum is the output bit; only the low WIDTH bits persist in acc.
    always_comb begin
        for (int c = 0; c < CHANNELS; c++) begin
            sd_sum[c] = {1'b0, acc[c*WIDTH +: WIDTH]} + {1'b0, cur_sample[c*WIDTH +: WIDTH]};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt         <= '0;
            sample_tick <= 1'b0;
            underrun    <= 1'b0;
            mode_act    <= 1'b0;
            cur_sample  <= '0;
            acc         <= '0;
            audio_out   <= '0;
        end else begin
            sample_tick <= boundary;
            if (ena) cnt <= (cnt == CNT_MAX) ? '0 : cnt + CW'(1);
            if (boundary) begin
                mode_act <= mode;
                if (fifo_vld) cur_sample <= fifo_dat;
            end
            if (boundary && !fifo_vld) underrun <= 1'b1;
            else if (clr_underrun)     underrun <= 1'b0;
            for (int c = 0; c < CHANNELS; c++) begin
                if (!ena) begin
                    audio_out[c] <= 1'b0;
                end else if (!mode_act) begin
                    audio_out[c] <= (phase < cur_sample[c*WIDTH +: WIDTH]);
                end else begin
                    audio_out[c]           <= sd_sum[c][WIDTH];
                    acc[c*WIDTH +: WIDTH] <= sd_sum[c][WIDTH-1:0];
                end
            end
        end
    end
endmodule

// File: tb/tb_audio_pdm_out.sv
// Bench for audio_pdm_out (2 ch, 4-bit, 32-cycle sample period, 4-deep FIFO).
module tb_audio_pdm_out;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       ena = 1'b0;
    logic       mode = 1'b0;
    logic       s_valid = 1'b0;
    logic       s_ready;
    logic [7:0] s_data = 8'h00;
    logic [1:0] audio_out;
    logic       sample_tick;
    logic       underrun;
    logic       clr_underrun = 1'b0;

    int total = 0;
    int bad   = 0;

    // Reference model state
    logic [7:0] m_q[$];
    int         m_cnt;
    logic [7:0] m_cur;
    int         m_acc[2];
    logic       m_mode;
    logic [1:0] m_out;
    logic       m_tick;
    logic       m_under;

    audio_pdm_out #(.CHANNELS(2), .WIDTH(4), .SAMPLE_DIV(32), .FIFO_DEPTH(4)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .ena          (ena),
        .mode         (mode),
        .s_valid      (s_valid),
        .s_ready      (s_ready),
        .s_data       (s_data),
        .audio_out    (audio_out),
        .sample_tick  (sample_tick),
        .underrun     (underrun),
        .clr_underrun (clr_underrun)
    );

    always #5 clk = ~clk;

    task automatic m_reset();
        m_q.delete();
        m_cnt = 0; m_cur = 8'h00; m_acc[0] = 0; m_acc[1] = 0;
        m_mode = 1'b0; m_out = 2'b00; m_tick = 1'b0; m_under = 1'b0;
    endtask

    // One clock period of the spec's behaviour, using the inputs present at the edge.
    task automatic model_update();
        bit   bnd, was_empty, can_push;
        int   v, s;
        bnd       = ena && (m_cnt == 31);
        was_empty = (m_q.size() == 0);
        can_push  = s_valid && (m_q.size() < 4);
        for (int c = 0; c < 2; c++) begin
            v = int'(m_cur[c*4 +: 4]);
            if (!ena) m_out[c] = 1'b0;
            else if (!m_mode) m_out[c] = ((m_cnt % 16) < v);
            else begin
                s = m_acc[c] + v;
                m_out[c] = (s >= 16);
                m_acc[c] = s % 16;
            end
        end
        m_tick = bnd;
        if (bnd) begin
            m_mode = mode;
            if (!was_empty) m_cur = m_q.pop_front();
        end
        if (bnd && was_empty) m_under = 1'b1;
        else if (clr_underrun) m_under = 1'b0;
        if (can_push) m_q.push_back(s_data);
        if (ena) m_cnt = (m_cnt + 1) % 32;
    endtask

    task automatic step();
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic test_reset();
        m_reset();
        repeat (2) @(posedge clk);
        #1;
        total++; if (audio_out !== 2'b00) begin bad++; $display("FAIL reset_audio got=%b want=00", audio_out); end
        total++; if (sample_tick !== 1'b0) begin bad++; $display("FAIL reset_tick got=%b want=0", sample_tick); end
        total++; if (underrun !== 1'b0) begin bad++; $display("FAIL reset_underrun got=%b want=0", underrun); end
        total++; if (s_ready !== 1'b1) begin bad++; $display("FAIL reset_ready got=%b want=1", s_ready); end
        rst_n = 1'b1;
    endtask

    task automatic test_pwm();
        int n0, n1;
        s_data = 8'hC4; s_valid = 1'b1; step(); s_valid = 1'b0;
        ena = 1'b1; mode = 1'b0;
        for (int i = 0; i < 40 && sample_tick !== 1'b1; i++) step();
        total++; if (sample_tick !== 1'b1) begin bad++; $display("FAIL pwm_tick_timeout got=%b want=1", sample_tick); end
        total++; if (underrun !== 1'b0) begin bad++; $display("FAIL pwm_underrun got=%b want=0", underrun); end
        n0 = 0; n1 = 0;
        for (int i = 0; i < 16; i++) begin
            step();
            n0 += int'(audio_out[0]); n1 += int'(audio_out[1]);
        end
        total++; if (n0 != 4) begin bad++; $display("FAIL pwm_ch0_high got=%0d want=4", n0); end
        total++; if (n1 != 12) begin bad++; $display("FAIL pwm_ch1_high got=%0d want=12", n1); end
    endtask

    task automatic test_sigma_delta();
        logic [3:0] vals[3] = '{4'd8, 4'd0, 4'd15};
        int         want[3] = '{8, 0, 15};
        int         n;
        bit         alt_ok;
        logic       prev;
        for (int k = 0; k < 3; k++) begin
            s_data = {4'($urandom_range(0, 15)), vals[k]}; s_valid = 1'b1; step();
        end
        s_valid = 1'b0; mode = 1'b1;
        for (int k = 0; k < 3; k++) begin
            for (int i = 0; i < 40 && sample_tick !== 1'b1; i++) step();
            total++; if (sample_tick !== 1'b1) begin bad++; $display("FAIL sd_tick_timeout k=%0d got=%b want=1", k, sample_tick); end
            n = 0; alt_ok = 1'b1; prev = 1'b0;
            for (int i = 0; i < 16; i++) begin
                step();
                n += int'(audio_out[0]);
                if (i > 0 && audio_out[0] === prev) alt_ok = 1'b0;
                prev = audio_out[0];
            end
            total++; if (n != want[k]) begin bad++; $display("FAIL sd_density v=%0d got=%0d want=%0d", vals[k], n, want[k]); end
            if (k == 0) begin
                total++; if (alt_ok !== 1'b1) begin bad++; $display("FAIL sd_alternate got=%b want=1", alt_ok); end
            end
        end
    endtask

    task automatic test_fifo_full();
        logic [7:0] fr[5];
        int n0, n1;
        for (int k = 0; k < 5; k++) fr[k] = 8'($urandom_range(0, 255));
        ena = 1'b0; mode = 1'b0;
        for (int k = 0; k < 4; k++) begin
            s_data = fr[k]; s_valid = 1'b1; step();
        end
        total++; if (s_ready !== 1'b0) begin bad++; $display("FAIL full_ready got=%b want=0", s_ready); end
        s_data = fr[4];
        repeat (3) step();
        total++; if (s_ready !== 1'b0) begin bad++; $display("FAIL full_hold_ready got=%b want=0", s_ready); end
        ena = 1'b1;
        for (int k = 0; k < 5; k++) begin
            for (int i = 0; i < 40 && sample_tick !== 1'b1; i++) step();
            total++; if (sample_tick !== 1'b1) begin bad++; $display("FAIL full_tick_timeout k=%0d got=%b want=1", k, sample_tick); end
            if (k == 0) begin
                total++; if (s_ready !== 1'b1) begin bad++; $display("FAIL full_ready_after_pop got=%b want=1", s_ready); end
            end
            n0 = 0; n1 = 0;
            for (int i = 0; i < 16; i++) begin
                step();
                if (i == 0) s_valid = 1'b0;
                n0 += int'(audio_out[0]); n1 += int'(audio_out[1]);
            end
            total++; if (n0 != int'(fr[k][3:0])) begin bad++; $display("FAIL order_ch0 k=%0d got=%0d want=%0d", k, n0, fr[k][3:0]); end
            total++; if (n1 != int'(fr[k][7:4])) begin bad++; $display("FAIL order_ch1 k=%0d got=%0d want=%0d", k, n1, fr[k][7:4]); end
        end
    endtask

    task automatic test_underrun();
        logic [7:0] last;
        int n0, n1;
        last = m_cur;
        for (int i = 0; i < 40 && sample_tick !== 1'b1; i++) step();
        total++; if (underrun !== 1'b1) begin bad++; $display("FAIL underrun_set got=%b want=1", underrun); end
        n0 = 0; n1 = 0;
        for (int i = 0; i < 16; i++) begin
            step();
            n0 += int'(audio_out[0]); n1 += int'(audio_out[1]);
        end
        total++; if (n0 != int'(last[3:0]) || n1 != int'(last[7:4]))
            begin bad++; $display("FAIL underrun_hold got=%0d/%0d want=%0d/%0d", n0, n1, last[3:0], last[7:4]); end
        clr_underrun = 1'b1; step();
        total++; if (underrun !== 1'b0) begin bad++; $display("FAIL underrun_clear got=%b want=0", underrun); end
        for (int i = 0; i < 40 && sample_tick !== 1'b1; i++) step();
        total++; if (underrun !== 1'b1) begin bad++; $display("FAIL underrun_set_wins got=%b want=1", underrun); end
        clr_underrun = 1'b0;
    endtask

    task automatic test_ena_freeze();
        int ticks, highs, n;
        clr_underrun = 1'b1; step(); clr_underrun = 1'b0;
        s_data = 8'hFF; s_valid = 1'b1; step(); s_valid = 1'b0;
        for (int i = 0; i < 40 && sample_tick !== 1'b1; i++) step();
        repeat (5) step();
        total++; if (audio_out !== 2'b11) begin bad++; $display("FAIL ena_running got=%b want=11", audio_out); end
        ena = 1'b0; step();
        total++; if (audio_out !== 2'b00) begin bad++; $display("FAIL ena_off_out got=%b want=00", audio_out); end
        ticks = 0; highs = 0;
        for (int i = 0; i < 40; i++) begin
            step();
            ticks += int'(sample_tick); highs += int'(audio_out != 2'b00);
        end
        total++; if (ticks != 0 || highs != 0) begin bad++; $display("FAIL ena_frozen ticks=%0d highs=%0d want=0/0", ticks, highs); end
        ena = 1'b1; n = 0;
        for (int i = 0; i < 40; i++) begin
            step(); n++;
            if (sample_tick === 1'b1) break;
        end
        total++; if (n != 27) begin bad++; $display("FAIL ena_resume_cycles got=%0d want=27", n); end
    endtask

    task automatic test_reset_mid();
        int highs;
        for (int k = 0; k < 4; k++) begin
            s_data = 8'hFF; s_valid = 1'b1; step();
        end
        s_valid = 1'b0;
        repeat (3) step();
        #3 rst_n = 1'b0; m_reset();
        #1;
        total++; if (audio_out !== 2'b00) begin bad++; $display("FAIL rst_mid_audio got=%b want=00", audio_out); end
        total++; if (underrun !== 1'b0 || sample_tick !== 1'b0)
            begin bad++; $display("FAIL rst_mid_flags got=%b%b want=00", underrun, sample_tick); end
        total++; if (s_ready !== 1'b1) begin bad++; $display("FAIL rst_mid_ready got=%b want=1", s_ready); end
        #2 rst_n = 1'b1;
        highs = 0;
        for (int i = 0; i < 40 && sample_tick !== 1'b1; i++) begin
            step(); highs += int'(audio_out != 2'b00);
        end
        total++; if (underrun !== 1'b1) begin bad++; $display("FAIL rst_mid_fifo_empty underrun=%b want=1", underrun); end
        total++; if (highs != 0) begin bad++; $display("FAIL rst_mid_sample_zero highs=%0d want=0", highs); end
    endtask

    task automatic test_random();
        logic [4:0] got, want;
        for (int cyc = 0; cyc < 1500; cyc++) begin
            ena          = ($urandom_range(0, 7) != 0);
            if ($urandom_range(0, 15) == 0) mode = ~mode;
            s_valid      = ($urandom_range(0, 2) == 0);
            s_data       = 8'($urandom_range(0, 255));
            clr_underrun = ($urandom_range(0, 9) == 0);
            step();
            got  = {audio_out, sample_tick, underrun, s_ready};
            want = {m_out, m_tick, m_under, (m_q.size() < 4)};
            total++; if (got !== want) begin bad++; $display("FAIL random cyc=%0d got=%b want=%b", cyc, got, want); end
        end
        s_valid = 1'b0; clr_underrun = 1'b0;
    endtask

    initial begin
        test_reset();
        test_pwm();
        test_sigma_delta();
        test_fifo_full();
        test_underrun();
        test_ena_freeze();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
